// File: rtl/run_chk_pkg.sv
// Shared types and helpers for the run-pattern checker.
// Holds the tracker state encoding, default widths and the pattern successor rule.
package run_chk_pkg;

   typedef enum logic [0:0] {StIdle, StRun} run_state_e;

   localparam int unsigned VW_DEF  = 3;
   localparam int unsigned LW_DEF  = 4;
   localparam int unsigned CW_DEF  = 8;
   localparam int unsigned LEN_MAX = (2 ** LW_DEF) - 1;

   // Successor in the run pattern: the top value wraps back to 1, never to 0.
   function automatic int unsigned nxt_val(input int unsigned v, input int unsigned vw);
      return (v == (2 ** vw) - 1) ? 1 : v + 1;
   endfunction

endpackage

// File: rtl/run_result_slot.sv
// Single-entry valid/ready holding register for completed-run results.
// A result arriving while the slot is full and not being popped is dropped and flagged.
module run_result_slot
   import run_chk_pkg::*;
#(
   parameter int unsigned VW = VW_DEF,
   parameter int unsigned LW = LW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [VW-1:0] res_value,
   input  logic [LW-1:0] res_len,
   input  logic          res_ok,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [VW-1:0] out_value,
   output logic [LW-1:0] out_len,
   output logic          out_ok,
   output logic          drop
);

   assign drop = load & out_valid & ~out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_value <= '0;
         out_len   <= '0;
         out_ok    <= 1'b0;
      end else if (load && (!out_valid || out_ready)) begin
         // Empty, or popped this same cycle: the new result takes the slot.
         out_valid <= 1'b1;
         out_value <= res_value;
         out_len   <= res_len;
         out_ok    <= res_ok;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/run_pattern_checker.sv
// Segments a sample stream into runs of equal value and checks each run against the
// 1,2,2,3,3,3,... pattern; one result per completed run plus saturating statistics.
module run_pattern_checker
   import run_chk_pkg::*;
#(
   parameter int unsigned VW = VW_DEF,
   parameter int unsigned LW = LW_DEF,
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [VW-1:0] in_value,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] out_value,
   output logic [LW-1:0] out_len,
   output logic          out_ok,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic          err_seen,
   output logic          ovf_seen
);

   localparam logic [LW-1:0] len_sat = '1;

   run_state_e    state_q;
   logic [VW-1:0] cur_val_q;
   logic [LW-1:0] cur_len_q;
   logic [VW-1:0] nxt;
   logic          done;
   logic          ok;
   logic          drop;

   always_comb begin
      nxt  = VW'(nxt_val(32'(cur_val_q), VW));
      done = in_valid && (state_q == StRun) && (in_value != cur_val_q);
      // A saturated length can no longer be trusted to equal the value.
      ok   = (cur_len_q == LW'(cur_val_q)) && (in_value == nxt) &&
             (cur_val_q != '0) && (cur_len_q != len_sat);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cur_val_q <= '0;
         cur_len_q <= '0;
      end else if (in_valid) begin
         unique case (state_q)
            StIdle: begin
               cur_val_q <= in_value;
               cur_len_q <= LW'(1);
               state_q   <= StRun;
            end
            StRun: begin
               if (in_value == cur_val_q) begin
                  if (cur_len_q != len_sat) cur_len_q <= cur_len_q + 1'b1;
               end else begin
                  cur_val_q <= in_value;
                  cur_len_q <= LW'(1);
               end
            end
         endcase
      end
   end

   // Statistics count every completion, including ones the slot had to drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
         err_seen <= 1'b0;
         ovf_seen <= 1'b0;
      end else begin
         if (done && ok && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
         if (done && !ok) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            err_seen <= 1'b1;
         end
         if (drop) ovf_seen <= 1'b1;
      end
   end

   run_result_slot #(
      .VW (VW),
      .LW (LW)
   ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (done),
      .res_value (cur_val_q),
      .res_len   (cur_len_q),
      .res_ok    (ok),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_value (out_value),
      .out_len   (out_len),
      .out_ok    (out_ok),
      .drop      (drop)
   );

endmodule

// File: tb/tb_run_pattern_checker.sv
// Bench for run_pattern_checker: vector table, hand-written corner sequences and
// random stimulus against a run-level reference model.
module tb_run_pattern_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [2:0] in_value = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [2:0] out_value;
   logic [3:0] out_len;
   logic       out_ok;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic       err_seen;
   logic       ovf_seen;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: current run (true, unbounded length) and the output slot.
   int m_active, m_rv, m_rl;
   int m_sv, m_val, m_len, m_ok;
   int m_pass, m_fail, m_err, m_ovf;

   typedef struct {
      bit iv;
      int v;
      bit rdy;
      bit ev;
      int eval;
      int elen;
      bit eok;
   } vec_t;

   vec_t tbl[17];

   always #5 clk = ~clk;

   run_pattern_checker #(
      .VW (3),
      .LW (4),
      .CW (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_len   (out_len),
      .out_ok    (out_ok),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt),
      .err_seen  (err_seen),
      .ovf_seen  (ovf_seen)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nxt_ref(input int v);
      return (v % 7) + 1;
   endfunction

   function automatic int sat(input int x, input int lim);
      return (x > lim) ? lim : x;
   endfunction

   task automatic model_reset();
      m_active = 0; m_rv = 0; m_rl = 0;
      m_sv = 0; m_val = 0; m_len = 0; m_ok = 0;
      m_pass = 0; m_fail = 0; m_err = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit iv, input int v, input bit rdy);
      bit done = 0;
      bit okb  = 0;
      int cv   = 0;
      int cl   = 0;
      if (iv) begin
         if (m_active == 0) begin
            m_active = 1; m_rv = v; m_rl = 1;
         end else if (v == m_rv) begin
            m_rl++;
         end else begin
            done = 1; cv = m_rv; cl = m_rl;
            okb = (m_rl == m_rv) && (v == nxt_ref(m_rv)) && (m_rv != 0) && (m_rl < 15);
            m_rv = v; m_rl = 1;
         end
      end
      if (done) begin
         if (m_sv != 0 && !rdy) m_ovf = 1;
         else begin
            m_sv = 1; m_val = cv; m_len = sat(cl, 15); m_ok = okb;
         end
         if (okb) m_pass = sat(m_pass + 1, 255);
         else begin
            m_fail = sat(m_fail + 1, 255);
            m_err = 1;
         end
      end else if (m_sv != 0 && rdy) begin
         m_sv = 0;
      end
   endtask

   task automatic compare_model();
      logic [31:0] a, e;
      logic [7:0]  ad, ed;
      ad = out_valid ? {out_value, out_len, out_ok} : 8'h00;
      ed = (m_sv != 0) ? {3'(m_val), 4'(m_len), 1'(m_ok)} : 8'h00;
      a = {5'b0, out_valid, ad, pass_cnt, fail_cnt, err_seen, ovf_seen};
      e = {5'b0, 1'(m_sv), ed, 8'(m_pass), 8'(m_fail), 1'(m_err), 1'(m_ovf)};
      check("model", a, e);
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
   task automatic cycle(input bit iv, input int v, input bit rdy);
      in_valid  = iv;
      in_value  = 3'(v);
      out_ready = rdy;
      model_step(iv, v, rdy);
      @(posedge clk);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("reset_outputs",
            {5'b0, out_valid, out_value, out_len, out_ok, pass_cnt, fail_cnt, err_seen, ovf_seen},
            32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ok_seen;
      int gen_v, gen_c, v;
      bit iv, rdy;

      tbl[0]  = '{1, 1, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 2, 1, 1, 1, 1, 1};
      tbl[2]  = '{1, 2, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 2, 1, 0, 0, 0, 0};
      tbl[4]  = '{1, 3, 1, 1, 2, 3, 0};
      tbl[5]  = '{0, 0, 1, 0, 0, 0, 0};
      tbl[6]  = '{1, 1, 1, 1, 3, 1, 0};
      tbl[7]  = '{1, 3, 1, 1, 1, 1, 0};
      tbl[8]  = '{1, 3, 1, 0, 0, 0, 0};
      tbl[9]  = '{1, 3, 1, 0, 0, 0, 0};
      tbl[10] = '{1, 2, 1, 1, 3, 3, 0};
      tbl[11] = '{0, 0, 1, 0, 0, 0, 0};
      tbl[12] = '{1, 2, 1, 0, 0, 0, 0};
      tbl[13] = '{0, 0, 1, 0, 0, 0, 0};
      tbl[14] = '{0, 0, 1, 0, 0, 0, 0};
      tbl[15] = '{1, 3, 1, 1, 2, 2, 1};
      tbl[16] = '{0, 0, 1, 0, 0, 0, 0};

      do_reset();

      // Wrong run length, skipped value and gaps.
      foreach (tbl[i]) begin
         cycle(tbl[i].iv, tbl[i].v, tbl[i].rdy);
         check($sformatf("tbl%0d", i),
               {23'b0, out_valid, (tbl[i].ev ? {out_value, out_len, out_ok} : 8'h00)},
               {23'b0, tbl[i].ev,
                (tbl[i].ev ? {3'(tbl[i].eval), 4'(tbl[i].elen), tbl[i].eok} : 8'h00)});
      end
      check("tbl_counts", {14'b0, pass_cnt, fail_cnt, err_seen, ovf_seen},
            {14'b0, 8'd2, 8'd4, 1'b1, 1'b0});

      // Clean pattern 1,2,2,...,7x7 then 1.
      do_reset();
      ok_seen = 0;
      for (int val = 1; val <= 7; val++) begin
         for (int r = 0; r < val; r++) begin
            cycle(1, val, 1);
            if (out_valid && out_ok) ok_seen++;
         end
      end
      cycle(1, 1, 1);
      if (out_valid && out_ok) ok_seen++;
      check("clean_results", 32'(ok_seen), 32'd7);
      check("clean_last", {24'b0, out_value, out_len, out_ok}, {24'b0, 3'd7, 4'd7, 1'b1});
      check("clean_counts", {14'b0, pass_cnt, fail_cnt, err_seen, ovf_seen},
            {14'b0, 8'd7, 8'd0, 1'b0, 1'b0});

      // Backpressure across two completions.
      do_reset();
      cycle(1, 1, 0);
      cycle(1, 2, 0);
      cycle(1, 2, 0);
      cycle(1, 3, 0);
      check("bp_held", {23'b0, out_valid, out_value, out_len, out_ok},
            {23'b0, 1'b1, 3'd1, 4'd1, 1'b1});
      check("bp_flags", {15'b0, pass_cnt, fail_cnt, ovf_seen}, {15'b0, 8'd2, 8'd0, 1'b1});
      cycle(0, 0, 1);
      check("bp_pop", {31'b0, out_valid}, 32'd0);

      // Reset in the middle of a run of 5s, then a saturating run of 4s.
      cycle(1, 5, 1);
      cycle(1, 5, 1);
      cycle(1, 5, 1);
      do_reset();
      cycle(1, 1, 1);
      for (int r = 0; r < 17; r++) cycle(1, 4, 1);
      cycle(1, 5, 1);
      check("sat_result", {23'b0, out_valid, out_value, out_len, out_ok},
            {23'b0, 1'b1, 3'd4, 4'd15, 1'b0});
      check("sat_counts", {15'b0, pass_cnt, fail_cnt, err_seen}, {15'b0, 8'd0, 8'd2, 1'b1});

      // Random, mostly pattern-following stimulus.
      do_reset();
      gen_v = 1;
      gen_c = 1;
      for (int n = 0; n < 800; n++) begin
         iv  = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 99) < 85) begin
            if (gen_c == 0) begin
               gen_v = nxt_ref(gen_v);
               gen_c = gen_v;
            end
            v = gen_v;
            if (iv) gen_c--;
         end else begin
            v = int'($urandom_range(0, 7));
         end
         cycle(iv, v, rdy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
